// File: rtl/mul32_seq.sv
// Sequential 32x32 shift-and-add multiplier that drives an external 64-bit ALU, one partial product per cycle.
// Optional signed support (magnitude multiply plus a final two's-complement FIX cycle) is enabled by MUL_SIGNED_EN.
module mul32_seq #(
    parameter logic [1:0] ADD_OP = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
`ifdef MUL_SIGNED_EN
    input  logic        sgn,
`endif
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic        alu_cin,
    output logic [1:0]  alu_op,
    input  logic [63:0] alu_s,
    input  logic        alu_cout,
    output logic        busy,
    output logic        done,
    output logic [63:0] p,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
`ifdef MUL_SIGNED_EN
        FIX  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] m_r;
    logic [31:0] q_r;
    logic [63:0] p_r;
    logic [4:0]  k_r;
    logic        ovf_r;
    logic        busy_r;
    logic        done_r;
    logic [63:0] alu_a_s;
    logic [63:0] alu_b_s;
    logic        alu_cin_s;
    state_t      after_busy_s;
    logic [31:0] x_cap_s;
    logic [31:0] y_cap_s;

`ifdef MUL_SIGNED_EN
    logic        neg_r;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as an unsigned value.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        mag32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    // Operand capture values and the post-BUSY state for the signed build.
    always_comb begin
        x_cap_s = sgn ? mag32(x) : x;
        y_cap_s = sgn ? mag32(y) : y;
        after_busy_s = neg_r ? FIX : DONE;
    end
`else
    // Operand capture values and the post-BUSY state for the unsigned build.
    always_comb begin
        x_cap_s = x;
        y_cap_s = y;
        after_busy_s = DONE;
    end
`endif

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Next-state logic and ALU operand steering.
    always_comb begin
        state_s   = state_r;
        alu_a_s   = 64'd0;
        alu_b_s   = 64'd0;
        alu_cin_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                alu_a_s = p_r;
                if (q_r[k_r]) begin
                    alu_b_s = {32'd0, m_r} << k_r;
                end else begin
                    alu_b_s = 64'd0;
                end
                if (k_r == 5'd31) begin
                    state_s = after_busy_s;
                end else begin
                    state_s = BUSY;
                end
            end
`ifdef MUL_SIGNED_EN
            FIX: begin
                alu_a_s   = ~p_r;
                alu_cin_s = 1'b1;
                state_s   = DONE;
            end
`endif
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: operand capture on accepted start, accumulation in BUSY, negation in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r   <= 32'd0;
            q_r   <= 32'd0;
            p_r   <= 64'd0;
            k_r   <= 5'd0;
            ovf_r <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        m_r   <= x_cap_s;
                        q_r   <= y_cap_s;
                        p_r   <= 64'd0;
                        k_r   <= 5'd0;
                        ovf_r <= 1'b0;
`ifdef MUL_SIGNED_EN
                        neg_r <= sgn & (x[31] ^ y[31]);
`endif
                    end
                end
                BUSY: begin
                    p_r <= alu_s;
                    k_r <= k_r + 5'd1;
                    if (alu_cout) begin
                        ovf_r <= 1'b1;
                    end
                end
`ifdef MUL_SIGNED_EN
                FIX: begin
                    p_r <= alu_s;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign alu_a   = alu_a_s;
    assign alu_b   = alu_b_s;
    assign alu_cin = alu_cin_s;
    assign alu_op  = ADD_OP;
    assign busy    = busy_r;
    assign done    = done_r;
    assign p       = p_r;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed self-checking bench for mul32_seq; the bench supplies the external 64-bit ALU.
// Signed vectors run only when MUL_SIGNED_EN is defined.
module tb_mul32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
`ifdef MUL_SIGNED_EN
    logic        sgn;
`endif
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic        alu_cin;
    logic [1:0]  alu_op;
    logic [63:0] alu_s;
    logic        alu_cout;
    logic        busy;
    logic        done;
    logic [63:0] p;
    logic        ovf;
    logic [64:0] sum65;

    int n_chk;
    int n_pass;

    mul32_seq #(.ADD_OP(2'b00)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
`ifdef MUL_SIGNED_EN
        .sgn(sgn),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_s(alu_s), .alu_cout(alu_cout),
        .busy(busy), .done(done), .p(p), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: op 00 adds, any other op yields a deliberately wrong result.
    assign sum65    = {1'b0, alu_a} + {1'b0, alu_b} + {64'd0, alu_cin};
    assign alu_s    = (alu_op == 2'b00) ? sum65[63:0] : (alu_a ^ alu_b);
    assign alu_cout = (alu_op == 2'b00) ? sum65[64] : 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_alu(input string tag);
        chk({tag, "_alu_a"}, alu_a, 64'd0);
        chk({tag, "_alu_b"}, alu_b, 64'd0);
        chk({tag, "_alu_cin"}, {63'd0, alu_cin}, 64'd0);
        chk({tag, "_alu_op"}, {62'd0, alu_op}, 64'd0);
    endtask

    // One multiply: start, optional stray start at edge T+inj+1, wait for done, check result and timing.
    task automatic run_mul(input string tag, input logic [31:0] xa, input logic [31:0] ya,
                           input logic sg, input logic [63:0] exp_b0, input logic [63:0] exp_p,
                           input int exp_lat, input int inj);
        int n;
        int bcnt;
        int dcnt;
        @(negedge clk);
        x = xa;
        y = ya;
`ifdef MUL_SIGNED_EN
        sgn = sg;
`endif
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        bcnt = busy ? 1 : 0;
        dcnt = done ? 1 : 0;
        chk({tag, "_busy0"}, {63'd0, busy}, 64'd1);
        chk({tag, "_alu_b0"}, alu_b, exp_b0);
        chk({tag, "_alu_op0"}, {62'd0, alu_op}, 64'd0);
        while (!done && n < 40) begin
            if (n == inj) begin
                start = 1'b1;
                x = 32'd7;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) dcnt++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_p"}, p, exp_p);
        chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
        chk({tag, "_busycnt"}, 64'(bcnt), 64'(exp_lat + 1));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_p_held"}, p, exp_p);
        chk({tag, "_ndone"}, 64'(dcnt), 64'd1);
        if (sg) begin
            chk({tag, "_sgn_ovf"}, {63'd0, ovf}, 64'd0);
        end
    endtask

    initial begin
        int n;
        int dseen;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        start  = 1'b1;
        x      = 32'd5;
        y      = 32'd5;
`ifdef MUL_SIGNED_EN
        sgn    = 1'b0;
`endif
        // Reset overrides start on the same edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_p", p, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk_idle_alu("rst");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF,
                64'hFFFF_FFFE_0000_0001, 32, -1);
        chk_idle_alu("max_after");
        run_mul("y0", 32'h1234_5678, 32'd0, 1'b0, 64'd0, 64'd0, 32, -1);
        run_mul("x0", 32'd0, 32'h9, 1'b0, 64'd0, 64'd0, 32, -1);
        run_mul("ign", 32'd3, 32'd5, 1'b0, 64'd3, 64'd15, 32, 9);

        // Abort mid-multiply with reset at edge T+16.
        @(negedge clk);
        x = 32'h0000_ABCD;
        y = 32'h0000_1234;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 15) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("abort_pre_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_p", p, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dseen++;
        end
        chk("abort_nodone", 64'(dseen), 64'd0);
        run_mul("after_abort", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'd0,
                64'h0000_0001_0000_0000, 32, -1);

        // Start held high through DONE is accepted only on the following IDLE cycle.
        @(negedge clk);
        x = 32'd2;
        y = 32'd3;
        start = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("hold_lat", 64'(n), 64'd32);
        chk("hold_p", p, 64'd6);
        @(posedge clk);
        @(negedge clk);
        chk("hold_idle", {63'd0, busy}, 64'd0);
        x = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("hold_reaccept", {63'd0, busy}, 64'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("hold2_lat", 64'(n), 64'd32);
        chk("hold2_p", p, 64'd12);

`ifdef MUL_SIGNED_EN
        run_mul("s_neg", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFF1, 33, -1);
        run_mul("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'd0,
                64'h4000_0000_0000_0000, 32, -1);
        run_mul("s_off", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0000_FFFF_FFFD,
                64'h0000_0004_FFFF_FFF1, 32, -1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 The module SHALL have parameter ADD_OP, default 2'b00, meaning the 2-bit ALU op code that selects s = a + b + cin on the downstream 64-bit ALU.
REQ-002 The module SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 The module SHALL have ports x and y, input, 32 each, multiplicand and multiplier, captured on the accepted start.
REQ-006 The module SHALL have port alu_a, output, 64, ALU operand a.
REQ-007 The module SHALL have port alu_b, output, 64, ALU operand b.
REQ-008 The module SHALL have port alu_cin, output, 1, ALU carry in.
REQ-009 The module SHALL have port alu_op, output, 2, ALU operation.
REQ-010 The module SHALL have port alu_s, input, 64, ALU sum.
REQ-011 The module SHALL have port alu_cout, input, 1, ALU carry out.
REQ-012 The module SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 The module SHALL have port done, output, 1, one-cycle pulse when the product is valid.
REQ-014 The module SHALL have port p, output, 64, product, held stable from done until the next accepted start.
REQ-015 The module SHALL have port ovf, output, 1, sticky flag for alu_cout = 1 seen in BUSY.

Function
REQ-016 States SHALL be IDLE, BUSY, FIX and DONE; FIX exists only as specified in Configuration.
REQ-017 In IDLE with start = 1 at edge T: capture M = {32'b0, x} and Q = y, clear P and ovf, clear counter k to 0, and go to BUSY.
REQ-018 In BUSY, combinationally: alu_a = P, alu_b = Q[k] ? (M << k) : 64'b0, alu_cin = 0, and alu_op = ADD_OP.
REQ-019 Each BUSY edge SHALL load P with alu_s and increment k; after k = 31, go to DONE (or FIX when it is enabled and needed).
REQ-020 Unsigned latency: BUSY spans edges T+1..T+32; DONE is occupied and done = 1 during the cycle after edge T+32; then return to IDLE.
REQ-021 Outside BUSY and FIX: alu_a = 0, alu_b = 0, alu_cin = 0, and alu_op = ADD_OP.
REQ-022 start while busy = 1 SHALL be ignored, and it SHALL NOT be queued.
REQ-023 start held high through DONE SHALL be accepted only on the IDLE cycle that follows.
REQ-024 p SHALL equal P; P is not modified outside BUSY/FIX except by rst or an accepted start.
REQ-025 ovf SHALL be set when alu_cout = 1 on a BUSY edge; this is unreachable with a correct ALU.

Reset
REQ-026 rst = 1 at any edge SHALL force IDLE, P = 0, k = 0, and ovf = 0, and SHALL clear the captured sign.
REQ-027 Outputs after reset SHALL be: busy = 0, done = 0, p = 0, and ovf = 0; alu_* as in REQ-021.
REQ-028 rst SHALL override start on the same edge.
REQ-029 rst asserted mid-BUSY/FIX SHALL abort with no done pulse.

Configuration
REQ-030 Macro MUL_SIGNED_EN SHALL control signed support; when defined, the module SHALL add port sgn, input, 1, sampled with start.
REQ-031 With the macro and sgn = 1: M and Q SHALL be captured as the magnitudes of x and y; neg = x[31] ^ y[31].
REQ-032 If neg = 1, one FIX cycle SHALL follow BUSY with alu_a = ~P, alu_b = 0, and alu_cin = 1; P SHALL load alu_s, then DONE follows; signed negative latency is done after edge T+33.
REQ-033 With the macro and sgn = 0, or neg = 0, timing SHALL be identical to unsigned.
REQ-034 Without the macro: no sgn port, no FIX state, and unsigned only.

Verification
REQ-035 x = 0xFFFFFFFF, y = 0xFFFFFFFF, start at T -> done pulse after T+32; p = 0xFFFFFFFE00000001; ovf = 0.
REQ-036 x = 0x12345678, y = 0 -> p = 0; also x = 0, y = 0x9 -> p = 0; busy is high for exactly 33 cycles each.
REQ-037 x = 3, y = 5 started; start pulsed again at T+10 with x = 7 -> ignored; p = 15; one done pulse only.
REQ-038 rst asserted at T+16 mid-multiply -> next cycle busy = 0, p = 0, and no done; a new start then completes normally.
REQ-039 With MUL_SIGNED_EN: sgn = 1, x = 0xFFFFFFFD (-3), y = 5 -> done after T+33; p = 0xFFFFFFFFFFFFFFF1.
REQ-040 With MUL_SIGNED_EN: sgn = 1, x = 0x80000000, y = 0x80000000 -> p = 0x4000000000000000 with no FIX cycle.
